// File: rtl/tcam_pkg.sv
// Shared widths and FSM state type for the TCAM segment-vector resolver.
package tcam_pkg;

    localparam int KWID   = 104;
    localparam int IDWID  = 8;
    localparam int SEGWID = IDWID + 2;
    localparam int NSEG   = KWID / IDWID;
    localparam int VTWID  = SEGWID * NSEG;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seg_field_sel.sv
// Combinational picker: returns {hit, wild, id} of segment i_idx from the captured vector.
module seg_field_sel #(
    parameter int IDWID  = tcam_pkg::IDWID,
    parameter int SEGWID = IDWID + 2,
    parameter int NSEG   = tcam_pkg::NSEG,
    parameter int VTWID  = SEGWID * NSEG,
    parameter int IDXW   = (NSEG > 1) ? $clog2(NSEG) : 1
) (
    input  logic [VTWID-1:0] i_vec,
    input  logic [IDXW-1:0]  i_idx,
    output logic             o_hit,
    output logic             o_wild,
    output logic [IDWID-1:0] o_id
);

    logic [SEGWID-1:0] w_seg;

    // Segment 0 sits at the top of the vector.
    always_comb begin
        w_seg = '0;
        for (int k = 0; k < NSEG; k++) begin
            if (i_idx == IDXW'(k))
                w_seg = i_vec[VTWID-1-k*SEGWID -: SEGWID];
        end
    end

    assign o_hit  = w_seg[SEGWID-1];
    assign o_wild = w_seg[SEGWID-2];
    assign o_id   = w_seg[IDWID-1:0];

endmodule

// File: rtl/seg_vector_resolver.sv
// Walks the per-segment match vector one segment per cycle and resolves a single rule ID
// (exact segments must agree; wildcard segments must not exceed the exact ID).
module seg_vector_resolver #(
    parameter int KWID   = tcam_pkg::KWID,
    parameter int IDWID  = tcam_pkg::IDWID,
    parameter int SEGWID = IDWID + 2,
    parameter int NSEG   = KWID / IDWID,
    parameter int VTWID  = SEGWID * NSEG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_Vector_Valid,
    output logic             o_Vector_Ready,
    input  logic [VTWID-1:0] i_Segment_Vector,
    output logic             o_Match_Valid,
    input  logic             i_Match_Ready,
    output logic             o_Match_Hit,
    output logic [IDWID-1:0] o_Match_ID,
    output logic             o_Busy
);

    import tcam_pkg::*;

    localparam int IDXW = (NSEG > 1) ? $clog2(NSEG) : 1;

    state_t           r_state, w_state_nxt;
    logic [IDXW-1:0]  r_idx, w_idx_nxt;
    logic [VTWID-1:0] r_vec;
    logic             r_seen, w_seen_nxt;
    logic [IDWID-1:0] r_cand, w_cand_nxt;
    logic [IDWID-1:0] r_max_wild, w_maxw_nxt;
    logic             r_vld, w_vld_nxt;
    logic             r_hit, w_hit_nxt;
    logic [IDWID-1:0] r_id, w_id_nxt;
    logic             w_cap_en;
    logic             w_miss;

    logic             w_seg_hit, w_seg_wild;
    logic [IDWID-1:0] w_seg_id;

    seg_field_sel #(
        .IDWID  (IDWID),
        .SEGWID (SEGWID),
        .NSEG   (NSEG),
        .VTWID  (VTWID),
        .IDXW   (IDXW)
    ) u_sel (
        .i_vec  (r_vec),
        .i_idx  (r_idx),
        .o_hit  (w_seg_hit),
        .o_wild (w_seg_wild),
        .o_id   (w_seg_id)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_seen_nxt  = r_seen;
        w_cand_nxt  = r_cand;
        w_maxw_nxt  = r_max_wild;
        w_vld_nxt   = r_vld;
        w_hit_nxt   = r_hit;
        w_id_nxt    = r_id;
        w_cap_en    = 1'b0;
        w_miss      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_Vector_Valid) begin
                    w_cap_en    = 1'b1;
                    w_idx_nxt   = '0;
                    w_seen_nxt  = 1'b0;
                    w_cand_nxt  = '0;
                    w_maxw_nxt  = '0;
                    w_state_nxt = ST_SCAN;
                end
            end

            ST_SCAN: begin
                if (!w_seg_hit) begin
                    w_miss = 1'b1;
                end else if (!w_seg_wild) begin
                    if (!r_seen) begin
                        w_seen_nxt = 1'b1;
                        w_cand_nxt = w_seg_id;
                    end else if (w_seg_id != r_cand) begin
                        w_miss = 1'b1;
                    end
                end else if (w_seg_id > r_max_wild) begin
                    w_maxw_nxt = w_seg_id;
                end

                // Final verdict uses the accumulators including the current segment.
                if (w_miss) begin
                    w_state_nxt = ST_DONE;
                    w_vld_nxt   = 1'b1;
                    w_hit_nxt   = 1'b0;
                    w_id_nxt    = '0;
                end else if (r_idx == IDXW'(NSEG-1)) begin
                    w_state_nxt = ST_DONE;
                    w_vld_nxt   = 1'b1;
                    if (!w_seen_nxt) begin
                        w_hit_nxt = 1'b1;
                        w_id_nxt  = w_maxw_nxt;
                    end else if (w_maxw_nxt <= w_cand_nxt) begin
                        w_hit_nxt = 1'b1;
                        w_id_nxt  = w_cand_nxt;
                    end else begin
                        w_hit_nxt = 1'b0;
                        w_id_nxt  = '0;
                    end
                end else begin
                    w_idx_nxt = r_idx + IDXW'(1);
                end
            end

            ST_DONE: begin
                if (i_Match_Ready) begin
                    w_state_nxt = ST_IDLE;
                    w_vld_nxt   = 1'b0;
                    w_hit_nxt   = 1'b0;
                    w_id_nxt    = '0;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_vld_nxt   = 1'b0;
                w_hit_nxt   = 1'b0;
                w_id_nxt    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx      <= '0;
            r_vec      <= '0;
            r_seen     <= 1'b0;
            r_cand     <= '0;
            r_max_wild <= '0;
            r_vld      <= 1'b0;
            r_hit      <= 1'b0;
            r_id       <= '0;
        end else begin
            if (w_cap_en) r_vec <= i_Segment_Vector;
            r_idx      <= w_idx_nxt;
            r_seen     <= w_seen_nxt;
            r_cand     <= w_cand_nxt;
            r_max_wild <= w_maxw_nxt;
            r_vld      <= w_vld_nxt;
            r_hit      <= w_hit_nxt;
            r_id       <= w_id_nxt;
        end
    end

    assign o_Vector_Ready = (r_state == ST_IDLE) && rst;
    assign o_Busy         = (r_state != ST_IDLE);
    assign o_Match_Valid  = r_vld;
    assign o_Match_Hit    = r_hit;
    assign o_Match_ID     = r_id;

endmodule

// File: doc/seg_vector_resolver.md
SEG_VECTOR_RESOLVER -- requirements
Module: seg_vector_resolver

Interface
REQ-001 SHALL have parameter KWID, default 104, meaning search key width.
REQ-002 SHALL have parameter IDWID, default 8, meaning rule ID width.
REQ-003 SHALL have parameter SEGWID, default IDWID+2, meaning segment field width ({hit, wild, id}).
REQ-004 SHALL have parameter NSEG, default KWID/IDWID (13), meaning segment count.
REQ-005 SHALL have parameter VTWID, default SEGWID*NSEG (130), meaning segment vector width.
REQ-006 SHALL have port clk, input, 1 bit, meaning the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit, meaning the reset, which is asynchronous and active-low.
REQ-008 SHALL have port i_Vector_Valid, input, 1 bit, meaning a segment vector is offered.
REQ-009 SHALL have port o_Vector_Ready, output, 1 bit, meaning the block accepts a vector.
REQ-010 SHALL have port i_Segment_Vector, input, VTWID bits, meaning the segment engine output; segment 0 occupies bits VTWID-1 down to VTWID-SEGWID.
REQ-011 SHALL have port o_Match_Valid, output, 1 bit, meaning the result is available.
REQ-012 SHALL have port i_Match_Ready, input, 1 bit, meaning the consumer takes the result.
REQ-013 SHALL have port o_Match_Hit, output, 1 bit, meaning a rule matched.
REQ-014 SHALL have port o_Match_ID, output, IDWID bits, meaning the matched rule ID.
REQ-015 SHALL have port o_Busy, output, 1 bit, meaning the state is not IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, SCAN and DONE.
REQ-017 SHALL assert o_Vector_Ready only in IDLE.
REQ-018 SHALL capture i_Segment_Vector on an edge where i_Vector_Valid and o_Vector_Ready are both 1, then clear idx to 0, clear the accumulators and enter SCAN.
REQ-019 SHALL evaluate exactly one segment per SCAN cycle, segment idx, in order from 0 to NSEG-1.
REQ-020 SHALL take, for each segment field, hit as bit SEGWID-1, wild as bit SEGWID-2 and id as the low IDWID bits.
REQ-021 SHALL, on hit=0, set the result to miss and enter DONE on the next edge (early exit).
REQ-022 SHALL, on hit=1 and wild=0, load cand=id and set seen=1 if seen=0; if seen=1 and id differs from cand, it SHALL set the result to miss and enter DONE.
REQ-023 SHALL, on hit=1 and wild=1, update max_wild to max(max_wild, id) as an unsigned IDWID-bit comparison.
REQ-024 SHALL, after segment NSEG-1 with no miss, enter DONE with o_Match_Hit=1 and o_Match_ID=cand if seen=1 and max_wild<=cand, with o_Match_Hit=0 if seen=1 and max_wild>cand, and with o_Match_Hit=1 and o_Match_ID=max_wild if seen=0.
REQ-025 SHALL give a latency of NSEG edges (13) from the accept edge to o_Match_Valid=1 on a full scan, and k+1 edges on an early exit at segment k.
REQ-026 SHALL hold o_Match_Valid, o_Match_Hit and o_Match_ID stable in DONE until i_Match_Ready=1, then return to IDLE on that edge.
REQ-027 SHALL keep o_Match_ID at 0 whenever o_Match_Hit=0.
REQ-028 SHALL ignore i_Segment_Vector changes after capture.
REQ-029 SHALL ignore i_Vector_Valid outside IDLE.
REQ-030 SHALL produce no output change while idle.

Reset
REQ-031 SHALL, while rst=0, force IDLE, idx=0, seen=0, cand=0, max_wild=0, o_Match_Valid=0, o_Match_Hit=0, o_Match_ID=0 and o_Busy=0, with o_Vector_Ready=1 once rst=1.
REQ-032 SHALL, on a reset asserted mid-SCAN or in DONE, abort immediately, discard the result and produce no o_Match_Valid after release.

Structure
REQ-033 SHALL place KWID, IDWID, SEGWID, NSEG, VTWID and the FSM state type in shared package tcam_pkg.
REQ-034 SHALL use one sub-module, seg_field_sel, which is combinational and extracts {hit, wild, id} for segment idx from the captured vector.

Verification
REQ-035 SHALL cover: all 13 segments {2'b10, 8'h05} -> o_Match_Hit=1, o_Match_ID=8'h05, o_Match_Valid high 13 cycles after accept.
REQ-036 SHALL cover: segment 3 with hit=0 and the rest exact 8'h02 -> o_Match_Hit=0, o_Match_ID=0, o_Match_Valid 4 cycles after accept.
REQ-037 SHALL cover: segments 4-7 exact 8'h09, segments 0-3 wild 8'h03, the rest wild 8'h00 -> hit, ID 8'h09; and the same vector with segment 0 wild 8'h0A -> miss.
REQ-038 SHALL cover: segment 2 exact 8'h01 and segment 5 exact 8'h02 -> miss, o_Match_Valid 6 cycles after accept.
REQ-039 SHALL cover: all segments wild, maximum 8'h07 -> hit, ID 8'h07; and i_Match_Ready held 0 for 5 cycles -> outputs stable with o_Vector_Ready=0 throughout.
REQ-040 SHALL cover: rst pulsed low at SCAN idx=6 -> outputs zero and o_Vector_Ready=1 after release, and the next vector resolves correctly.
